imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader: the write-side counterpart of the core's instruction-memory read port.
- Accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit words and writes them into instruction memory at consecutive word addresses.
- Holds the core in reset during loading, then releases it with `initial_address` driven to `BASE_ADDR`.
- Sits between a byte source (UART RX or testbench) and the instruction memory write port and core reset.

Parameters:
- DEPTH, 1024: instruction memory capacity in 32-bit words; upper bound on loadable word count.
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word; also the core start address.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a rising edge
- restart  input  1  single-cycle pulse; begins a new load from DONE or ERROR
- imem_we  output  1  one-cycle write strobe to instruction memory
- imem_addr  output  32  byte address of the write (word aligned)
- imem_wdata  output  32  word to write
- core_reset  output  1  held high while the core must not run
- initial_address  output  32  core start address, constant BASE_ADDR
- busy  output  1  high in HDR or DATA
- error  output  1  high in ERROR
- words_loaded  output  32  count of words written in the current load

Behaviour:
Reset values:
- State = HDR; in_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; core_reset=1; busy=1; error=0; words_loaded=0.
- Byte index = 0; header count = 0.

Stream format:
- 4-byte little-endian word count N, then N words of 4 bytes each, least-significant byte first.

States:
- HDR
  - in_ready=1.
  - Each accepted byte is placed at count[8*idx +: 8]; idx increments mod 4.
  - On the 4th byte: N==0 -> DONE; N>DEPTH -> ERROR; otherwise -> DATA with idx=0, words_loaded=0.
- DATA
  - in_ready=1 every cycle, including the cycle imem_we is high. No back-pressure; the byte buffer is independent of imem_wdata.
  - Bytes assemble into a word buffer.
  - On acceptance of the 4th byte of a word, the next cycle drives registered outputs: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = BASE_ADDR + 4*words_loaded (old value), words_loaded increments.
  - When the incremented words_loaded == N, the state becomes DONE in that same cycle.
- DONE
  - in_ready=0; core_reset=0; busy=0.
  - Held until restart or reset.
- ERROR
  - in_ready=0; core_reset=1; error=1; busy=0.
  - Held until restart or reset.

Outputs and address arithmetic:
- core_reset is registered. It falls on the same edge the final imem_we is issued, so the write completes before the core's first fetch edge.
- Address arithmetic is 32-bit and wraps modulo 2^32; no check beyond N<=DEPTH.

Boundary conditions:
- in_valid low mid-word: partial bytes are retained indefinitely; no timeout.
- in_valid while in_ready=0: ignored; the byte is not consumed.
- restart in DONE or ERROR: next cycle -> HDR, core_reset=1, error=0, idx=0, words_loaded=0.
- restart in HDR or DATA: ignored.
- restart and an accepted byte in the same cycle: the byte is processed; restart is ignored.
- N==DEPTH: accepted; N==DEPTH+1: ERROR.
- reset asserted mid-load: immediate return to reset values. Already-written memory words are not erased.

Test Plan:
1. Stream 02 00 00 00, 13 05 50 00, 93 05 A0 00 with in_valid held high -> imem_we pulses twice; (addr 0x0, data 0x00500513) then (addr 0x4, data 0x00A00593); words_loaded=2; core_reset falls with the second pulse; busy=0.
2. BASE_ADDR=0x100, N=1, word 0xDEADBEEF with 3-cycle in_valid gaps between bytes -> single write at addr 0x100, data 0xDEADBEEF; no spurious imem_we during gaps.
3. Header 00 00 00 00 -> DONE after the 4th byte; no imem_we; core_reset=0; words_loaded=0.
4. Header N=1025 with DEPTH=1024 -> ERROR; error=1, core_reset=1, in_ready=0. Pulse restart, then load N=1024 -> 1024 writes; last at addr 0xFFC; DONE reached.
5. Assert reset after 2 bytes of the second word of an N=3 load -> all outputs return to reset values at once. Reload N=1 -> the first write goes to BASE_ADDR with only new bytes (no stale bytes).
6. In DONE, pulse restart while in_valid is high -> core_reset=1 the next cycle; the following 4 bytes are taken as a new header.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader for the instruction memory.
// Takes a byte stream (4-byte little-endian word count, then that many
// little-endian words), writes the words to consecutive word addresses
// starting at BASE_ADDR, and keeps the core in reset until the last word
// has been written.
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic [31:0] initial_address,
    output logic        busy,
    output logic        error,
    output logic [31:0] words_loaded
);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] word_count;
    logic [31:0] word_buf;
    logic        accept;
    logic [31:0] hdr_word;
    logic [31:0] data_word;
    logic [31:0] next_loaded;

    // A byte moves only when both sides agree; the 4th byte of a header or
    // word completes the value together with the three already buffered.
    assign accept          = in_valid && in_ready;
    assign hdr_word        = {in_data, word_count[23:0]};
    assign data_word       = {in_data, word_buf[23:0]};
    assign next_loaded     = words_loaded + 32'd1;
    assign initial_address = BASE_ADDR;

    // Loader state machine; every output is registered here so the memory
    // write and the core reset release happen on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_HDR;
            byte_idx     <= 2'd0;
            word_count   <= 32'd0;
            word_buf     <= 32'd0;
            in_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= 32'd0;
            imem_wdata   <= 32'd0;
            core_reset   <= 1'b1;
            busy         <= 1'b1;
            error        <= 1'b0;
            words_loaded <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (accept) begin
                        word_count[8*byte_idx +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (hdr_word == 32'd0) begin
                                state      <= ST_DONE;
                                in_ready   <= 1'b0;
                                core_reset <= 1'b0;
                                busy       <= 1'b0;
                            end else if (hdr_word > 32'(DEPTH)) begin
                                state    <= ST_ERROR;
                                in_ready <= 1'b0;
                                error    <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                state        <= ST_DATA;
                                words_loaded <= 32'd0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        word_buf[8*byte_idx +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= data_word;
                            imem_addr    <= BASE_ADDR + {words_loaded[29:0], 2'b00};
                            words_loaded <= next_loaded;
                            if (next_loaded == word_count) begin
                                state      <= ST_DONE;
                                in_ready   <= 1'b0;
                                core_reset <= 1'b0;
                                busy       <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (restart) begin
                        state        <= ST_HDR;
                        byte_idx     <= 2'd0;
                        word_count   <= 32'd0;
                        words_loaded <= 32'd0;
                        in_ready     <= 1'b1;
                        core_reset   <= 1'b1;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one default instance (BASE_ADDR 0,
// DEPTH 1024) and one instance with BASE_ADDR 0x100 for the gapped stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [7:0]  a_in_data = 8'd0;
    logic        a_in_valid = 1'b0;
    logic        a_restart = 1'b0;
    logic        a_in_ready, a_imem_we, a_core_reset, a_busy, a_error;
    logic [31:0] a_imem_addr, a_imem_wdata, a_initial_address, a_words_loaded;

    logic [7:0]  b_in_data = 8'd0;
    logic        b_in_valid = 1'b0;
    logic        b_restart = 1'b0;
    logic        b_in_ready, b_imem_we, b_core_reset, b_busy, b_error;
    logic [31:0] b_imem_addr, b_imem_wdata, b_initial_address, b_words_loaded;

    logic [31:0] a_addr_q[$];
    logic [31:0] a_data_q[$];
    logic [31:0] b_addr_q[$];
    logic [31:0] b_data_q[$];

    int vectors = 0;
    int miscompares = 0;

    imem_loader dut (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .restart(a_restart),
        .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
        .core_reset(a_core_reset), .initial_address(a_initial_address),
        .busy(a_busy), .error(a_error), .words_loaded(a_words_loaded)
    );

    imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0100)) dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .restart(b_restart),
        .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .core_reset(b_core_reset), .initial_address(b_initial_address),
        .busy(b_busy), .error(b_error), .words_loaded(b_words_loaded)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Log every memory write seen mid-cycle, one entry per strobe.
    always @(negedge clk) begin
        if (a_imem_we) begin
            a_addr_q.push_back(a_imem_addr);
            a_data_q.push_back(a_imem_wdata);
        end
        if (b_imem_we) begin
            b_addr_q.push_back(b_imem_addr);
            b_data_q.push_back(b_imem_wdata);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    // Present one byte with in_valid high for one clock; returns just after
    // the following falling edge with in_valid still high.
    task automatic apply_stimulus(input bit sel, input logic [7:0] b);
        if (sel == 1'b0) begin
            a_in_data  = b;
            a_in_valid = 1'b1;
        end else begin
            b_in_data  = b;
            b_in_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit sel, input int n);
        if (sel == 1'b0) a_in_valid = 1'b0;
        else             b_in_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic apply_word(input bit sel, input logic [31:0] w);
        for (int k = 0; k < 4; k++) apply_stimulus(sel, w[8*k +: 8]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        a_addr_q.delete(); a_data_q.delete();
        b_addr_q.delete(); b_data_q.delete();
    endtask

    initial begin
        $display("[TB] imem_loader directed test start");
        do_reset();

        // Reset values
        check_output("rst_in_ready",   a_in_ready,        32'd1);
        check_output("rst_imem_we",    a_imem_we,         32'd0);
        check_output("rst_imem_addr",  a_imem_addr,       32'd0);
        check_output("rst_imem_wdata", a_imem_wdata,      32'd0);
        check_output("rst_core_reset", a_core_reset,      32'd1);
        check_output("rst_busy",       a_busy,            32'd1);
        check_output("rst_error",      a_error,           32'd0);
        check_output("rst_words",      a_words_loaded,    32'd0);
        check_output("rst_init_addr",  a_initial_address, 32'd0);
        check_output("rst_init_addr_b", b_initial_address, 32'h0000_0100);

        // 1: two-word program streamed back to back
        apply_word(0, 32'd2);
        apply_word(0, 32'h0050_0513);
        apply_stimulus(0, 8'h93);
        apply_stimulus(0, 8'h05);
        apply_stimulus(0, 8'hA0);
        check_output("t1_core_reset_hold", a_core_reset,   32'd1);
        check_output("t1_busy_hold",       a_busy,         32'd1);
        check_output("t1_words_mid",       a_words_loaded, 32'd1);
        apply_stimulus(0, 8'h00);
        check_output("t1_we_last",         a_imem_we,      32'd1);
        check_output("t1_core_reset_fall", a_core_reset,   32'd0);
        check_output("t1_busy_done",       a_busy,         32'd0);
        check_output("t1_in_ready_done",   a_in_ready,     32'd0);
        check_output("t1_words",           a_words_loaded, 32'd2);
        idle(0, 1);
        check_output("t1_we_single",       a_imem_we,      32'd0);
        check_output("t1_write_count",     a_addr_q.size(), 32'd2);
        if (a_addr_q.size() == 2) begin
            check_output("t1_addr0", a_addr_q[0], 32'h0000_0000);
            check_output("t1_data0", a_data_q[0], 32'h0050_0513);
            check_output("t1_addr1", a_addr_q[1], 32'h0000_0004);
            check_output("t1_data1", a_data_q[1], 32'h00A0_0593);
        end

        // 2: BASE_ADDR 0x100, one word with 3-cycle gaps between bytes
        apply_word(1, 32'd1);
        idle(1, 3);
        apply_stimulus(1, 8'hEF); idle(1, 3);
        apply_stimulus(1, 8'hBE); idle(1, 3);
        apply_stimulus(1, 8'hAD); idle(1, 3);
        check_output("t2_no_write_in_gaps", b_addr_q.size(), 32'd0);
        check_output("t2_core_reset_hold",  b_core_reset,    32'd1);
        apply_stimulus(1, 8'hDE);
        idle(1, 3);
        check_output("t2_write_count", b_addr_q.size(), 32'd1);
        if (b_addr_q.size() == 1) begin
            check_output("t2_addr", b_addr_q[0], 32'h0000_0100);
            check_output("t2_data", b_data_q[0], 32'hDEAD_BEEF);
        end
        check_output("t2_core_reset", b_core_reset,   32'd0);
        check_output("t2_words",      b_words_loaded, 32'd1);

        // 3: empty program goes straight to DONE
        do_reset();
        apply_word(0, 32'd0);
        idle(0, 2);
        check_output("t3_no_write",   a_addr_q.size(), 32'd0);
        check_output("t3_core_reset", a_core_reset,    32'd0);
        check_output("t3_busy",       a_busy,          32'd0);
        check_output("t3_in_ready",   a_in_ready,      32'd0);
        check_output("t3_words",      a_words_loaded,  32'd0);

        // 4: N = DEPTH+1 rejected, restart, then N = DEPTH accepted
        do_reset();
        apply_word(0, 32'd1025);
        idle(0, 1);
        check_output("t4_error",      a_error,      32'd1);
        check_output("t4_core_reset", a_core_reset, 32'd1);
        check_output("t4_in_ready",   a_in_ready,   32'd0);
        check_output("t4_busy",       a_busy,       32'd0);
        a_restart = 1'b1;
        @(negedge clk);
        a_restart = 1'b0;
        #1;
        check_output("t4_rs_error",    a_error,      32'd0);
        check_output("t4_rs_in_ready", a_in_ready,   32'd1);
        check_output("t4_rs_busy",     a_busy,       32'd1);
        apply_word(0, 32'd1024);
        for (int w = 0; w < 1024; w++) apply_word(0, 32'(w) ^ 32'h5A00_0000);
        idle(0, 1);
        check_output("t4_write_count", a_addr_q.size(), 32'd1024);
        if (a_addr_q.size() == 1024) begin
            check_output("t4_first_addr", a_addr_q[0],    32'h0000_0000);
            check_output("t4_first_data", a_data_q[0],    32'h5A00_0000);
            check_output("t4_last_addr",  a_addr_q[1023], 32'h0000_0FFC);
            check_output("t4_last_data",  a_data_q[1023], 32'h5A00_03FF);
        end
        check_output("t4_words",      a_words_loaded, 32'd1024);
        check_output("t4_core_reset", a_core_reset,   32'd0);
        check_output("t4_done_error", a_error,        32'd0);

        // 5: reset mid-word, then reload without stale bytes
        do_reset();
        apply_word(0, 32'd3);
        apply_word(0, 32'h4433_2211);
        apply_stimulus(0, 8'hAA);
        apply_stimulus(0, 8'hBB);
        reset = 1'b1;
        a_in_valid = 1'b0;
        #1;
        check_output("t5_rst_words",      a_words_loaded, 32'd0);
        check_output("t5_rst_wdata",      a_imem_wdata,   32'd0);
        check_output("t5_rst_addr",       a_imem_addr,    32'd0);
        check_output("t5_rst_core_reset", a_core_reset,   32'd1);
        check_output("t5_rst_in_ready",   a_in_ready,     32'd1);
        check_output("t5_rst_busy",       a_busy,         32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        a_addr_q.delete(); a_data_q.delete();
        apply_word(0, 32'd1);
        apply_word(0, 32'h8877_6655);
        idle(0, 1);
        check_output("t5_write_count", a_addr_q.size(), 32'd1);
        if (a_addr_q.size() == 1) begin
            check_output("t5_addr", a_addr_q[0], 32'h0000_0000);
            check_output("t5_data", a_data_q[0], 32'h8877_6655);
        end

        // 6: restart in DONE with in_valid high; byte on that cycle is not taken
        a_addr_q.delete(); a_data_q.delete();
        a_in_data  = 8'h01;
        a_in_valid = 1'b1;
        a_restart  = 1'b1;
        @(negedge clk);
        a_restart = 1'b0;
        #1;
        check_output("t6_core_reset", a_core_reset,   32'd1);
        check_output("t6_in_ready",   a_in_ready,     32'd1);
        check_output("t6_words",      a_words_loaded, 32'd0);
        apply_word(0, 32'd1);
        apply_word(0, 32'hCAFE_F00D);
        idle(0, 1);
        check_output("t6_write_count", a_addr_q.size(), 32'd1);
        if (a_addr_q.size() == 1) begin
            check_output("t6_addr", a_addr_q[0], 32'h0000_0000);
            check_output("t6_data", a_data_q[0], 32'hCAFE_F00D);
        end
        check_output("t6_done_core_reset", a_core_reset, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
